// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, FSM state encoding
// and the canonical NOP instruction word.
package rv_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'b00;
    localparam fsm_state_t ST_FETCH = 2'b01;
    localparam fsm_state_t ST_EXEC  = 2'b10;
    localparam fsm_state_t ST_ERROR = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or JALR target,
// plus a misalignment flag for targets that are not word aligned.
module next_pc_calc
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;

    // All additions wrap modulo 2^32; carries are intentionally dropped.
    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc + imm_ext;
    assign jalr_tgt   = alu_result & 32'hFFFF_FFFE;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_PLUS4:  next_pc = pc_plus4;
            PCSRC_BRANCH: next_pc = branch_tgt;
            PCSRC_JALR:   next_pc = jalr_tgt;
            default:      next_pc = pc_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, holds it for execute, then
// advances pc from the next-PC calculator. Timeouts and bad targets are terminal.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        stall,
    output logic        fetch_err
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    fsm_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .misaligned (next_pc_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A ready on the final allowed cycle still completes the fetch.
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_EXEC;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (next_pc_misaligned) begin
                        state_d = ST_ERROR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign fetch_err   = (state_q == ST_ERROR);

endmodule
